// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//
// APB slave backed by a DEPTH x WIDTH register array. Each transfer is
// latched in the setup cycle, optionally delayed by WAIT_CYCLES wait states,
// then completed with a one-cycle PREADY pulse. Addresses >= DEPTH complete
// with PSLVERR=1, read back as zero and never modify the array.
//
// Ports
//   i_PCLK     : clock, rising edge
//   i_PRESETn  : asynchronous active-low reset (clears state and array)
//   i_PSEL     : slave select
//   i_PENABLE  : access-phase strobe
//   i_PWRITE   : 1 = write, 0 = read
//   i_PADDR    : transfer address (WIDTH bits)
//   i_PWDATA   : write data (WIDTH bits)
//   o_PRDATA   : read data, nonzero only while o_PREADY=1
//   o_PREADY   : registered transfer completion pulse
//   o_PSLVERR  : registered error flag, qualified by o_PREADY
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             i_PCLK,
    input  logic             i_PRESETn,
    input  logic             i_PSEL,
    input  logic             i_PENABLE,
    input  logic             i_PWRITE,
    input  logic [WIDTH-1:0] i_PADDR,
    input  logic [WIDTH-1:0] i_PWDATA,
    output logic [WIDTH-1:0] o_PRDATA,
    output logic             o_PREADY,
    output logic             o_PSLVERR
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**WIDTH is representable in the compare.
    localparam logic [WIDTH:0] DEPTH_W  = (WIDTH+1)'(DEPTH);
    localparam logic [3:0]     CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] prdata_q, prdata_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic [DEPTH-1:0] wr_sel;

    // Next-state, latching and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        err_d     = err_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_PSEL && !i_PENABLE) begin
                    addr_d  = i_PADDR;
                    wdata_d = i_PWDATA;
                    wr_d    = i_PWRITE;
                    err_d   = ({1'b0, i_PADDR} >= DEPTH_W);
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                // Dropping PSEL mid-transfer abandons it silently.
                if (!i_PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are computed from the next state so they are valid in
        // exactly the cycle the FSM sits in READY. The read uses addr_d so a
        // zero-wait transfer sees the address latched on the same edge.
        if (state_d == ST_READY) begin
            pready_d  = 1'b1;
            pslverr_d = err_d;
            if (!wr_d && !err_d) begin
                prdata_d = mem_q[addr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // The write commits on the edge leaving READY, so a read set up in the
    // following cycle already observes it.
    assign wr_en = (state_q == ST_READY) && wr_q && !err_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wr_sel[gi] = wr_en && (addr_q[AW-1:0] == AW'(gi));
        end
    endgenerate

    // Array must be clearable by reset, so it is built from flops.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_q[i] <= wdata_q;
                end
            end
        end
    end

    assign o_PRDATA  = prdata_q;
    assign o_PREADY  = pready_q;
    assign o_PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

    typedef struct {
        int         inst;
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata [3];
    logic [2:0] pready;
    logic [2:0] pslverr;

    int   checks;
    int   errors;
    int   cyc;
    exp_t q[$];

    // Three slaves differing only in wait states: 0, 3 and 2.
    apb_slave_regfile #(.WIDTH(8), .DEPTH(64), .WAIT_CYCLES(0)) u0 (
        .i_PCLK(clk), .i_PRESETn(rst_n), .i_PSEL(psel[0]), .i_PENABLE(penable),
        .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
        .o_PRDATA(prdata[0]), .o_PREADY(pready[0]), .o_PSLVERR(pslverr[0]));

    apb_slave_regfile #(.WIDTH(8), .DEPTH(64), .WAIT_CYCLES(3)) u1 (
        .i_PCLK(clk), .i_PRESETn(rst_n), .i_PSEL(psel[1]), .i_PENABLE(penable),
        .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
        .o_PRDATA(prdata[1]), .o_PREADY(pready[1]), .o_PSLVERR(pslverr[1]));

    apb_slave_regfile #(.WIDTH(8), .DEPTH(64), .WAIT_CYCLES(2)) u2 (
        .i_PCLK(clk), .i_PRESETn(rst_n), .i_PSEL(psel[2]), .i_PENABLE(penable),
        .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
        .o_PRDATA(prdata[2]), .o_PREADY(pready[2]), .o_PSLVERR(pslverr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(input int inst);
        if (inst == 1) return 3;
        if (inst == 2) return 2;
        return 0;
    endfunction

    // Monitor: every completion pulse is matched against the scoreboard,
    // including the cycle it must appear in.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (pready[i]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pready inst=%0d cyc=%0d got PREADY=1 required PREADY=0", i, cyc);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        if (e.inst != i || prdata[i] !== e.rdata || pslverr[i] !== e.err || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL response inst=%0d got prdata=%02h slverr=%0b cyc=%0d required inst=%0d prdata=%02h slverr=%0b cyc=%0d",
                                     i, prdata[i], pslverr[i], cyc, e.inst, e.rdata, e.err, e.cyc);
                        end else begin
                            $display("ok   inst=%0d prdata=%02h slverr=%0b cyc=%0d", i, prdata[i], pslverr[i], cyc);
                        end
                    end
                end else begin
                    checks++;
                    if (prdata[i] !== 8'h00 || pslverr[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_outputs inst=%0d cyc=%0d got prdata=%02h slverr=%0b required prdata=00 slverr=0",
                                 i, cyc, prdata[i], pslverr[i]);
                    end
                end
            end
        end
    end

    // Full transfer; called aligned 1 time unit after a rising edge and
    // returns aligned the same way, so consecutive calls are back-to-back.
    task automatic xfer(input int inst, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata,
                        input logic exp_err);
        int  n;
        bit  done;
        exp_t e;
        psel       = 3'b000;
        psel[inst] = 1'b1;
        penable    = 1'b0;
        pwrite     = wr;
        paddr      = addr;
        pwdata     = wdata;
        e.inst  = inst;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + 1 + wait_of(inst);
        q.push_back(e);
        @(posedge clk); #1;
        // Bus payload changes after setup must be ignored by the slave.
        penable = 1'b1;
        pwrite  = ~wr;
        paddr   = ~addr;
        pwdata  = ~wdata;
        n = 0;
        done = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            if (pready[inst]) done = 1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout inst=%0d addr=%02h got no PREADY required PREADY within 20 cycles", inst, addr);
        end
        @(posedge clk); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Seed a value so the reset clear is observable.
        xfer(0, 1'b1, 8'd5, 8'h77, 8'h00, 1'b0);

        // Read addr 5 and assert reset during its READY cycle.
        psel    = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'd5;
        @(posedge clk); #1;
        penable = 1'b1;
        checks++;
        if (pready[0] !== 1'b1 || prdata[0] !== 8'h77) begin
            errors++;
            $display("FAIL pre_reset_ready got pready=%0b prdata=%02h required pready=1 prdata=77", pready[0], prdata[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pready[i] !== 1'b0 || prdata[i] !== 8'h00 || pslverr[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset inst=%0d got pready=%0b prdata=%02h slverr=%0b required all 0",
                         i, pready[i], prdata[i], pslverr[i]);
            end else begin
                $display("ok   async_reset inst=%0d outputs cleared", i);
            end
        end
        @(posedge clk); #1;
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Array cleared by reset.
        xfer(0, 1'b0, 8'd5, 8'h00, 8'h00, 1'b0);

        // Zero-wait write then back-to-back read.
        xfer(0, 1'b1, 8'd3, 8'hA5, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'd3, 8'h00, 8'hA5, 1'b0);

        // Three wait states.
        xfer(1, 1'b1, 8'd7, 8'h3C, 8'h00, 1'b0);
        xfer(1, 1'b0, 8'd7, 8'h00, 8'h3C, 1'b0);

        // Out-of-range handling.
        xfer(0, 1'b1, 8'd63, 8'h42, 8'h00, 1'b0);
        xfer(0, 1'b1, 8'd64, 8'hFF, 8'h00, 1'b1);
        xfer(0, 1'b0, 8'd63, 8'h00, 8'h42, 1'b0);
        xfer(0, 1'b0, 8'd64, 8'h00, 8'h00, 1'b1);
        xfer(0, 1'b0, 8'hC0, 8'h00, 8'h00, 1'b1);

        // Aborted write on the two-wait slave: PSEL dropped in T1.
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd9;
        pwdata  = 8'h11;
        @(posedge clk); #1;
        psel    = 3'b000;
        repeat (5) @(posedge clk);
        #1;
        xfer(2, 1'b0, 8'd9, 8'h00, 8'h00, 1'b0);

        // Boundary addresses, no aliasing.
        xfer(0, 1'b1, 8'd63, 8'h80, 8'h00, 1'b0);
        xfer(0, 1'b1, 8'd0,  8'h01, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'd63, 8'h00, 8'h80, 1'b0);
        xfer(0, 1'b0, 8'd0,  8'h00, 8'h01, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending responses required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
